// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the receive-side destination-MAC filter.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam mac_addr_t  MAC_BCAST        = 48'hFFFF_FFFF_FFFF;
  localparam int         ETH_HDR_DA_BYTES = 6;
  localparam logic [2:0] HDR_LAST_IDX     = 3'd5;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    FLUSH = 2'd1,
    PASS  = 2'd2,
    DROP  = 2'd3
  } filter_state_t;

  // Destination address comparison, optionally also admitting broadcast.
  function automatic logic mac_match(input mac_addr_t da, input mac_addr_t addr,
                                     input logic bcast_en);
    return (da == addr) || (bcast_en && (da == MAC_BCAST));
  endfunction

endpackage

// File: rtl/mac_filter.sv
// Byte-wide AXI4-Stream destination-MAC filter: buffers the 6-byte DA, replays it
// for matching frames and then passes the payload through; non-matching frames are sunk.
module mac_filter
  import eth_pkg::*;
#(
  parameter mac_addr_t MAC_ADDR     = 48'hDEADBEEF1234,
  parameter logic      ACCEPT_BCAST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_tvalid,
  output logic       in_tready,
  input  logic [7:0] in_tdata,
  input  logic       in_tlast,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic [7:0] out_tdata,
  output logic       out_tlast
);

  filter_state_t state_r, state_nxt;
  logic [2:0]    cnt_r, cnt_nxt;
  logic [2:0]    idx_s;
  logic [7:0]    hdr_buf_r [ETH_HDR_DA_BYTES];
  logic          last_r, last_nxt;
  logic          run_r;
  logic          ov_r, ov_nxt;
  logic [7:0]    od_r, od_nxt;
  logic          ol_r, ol_nxt;
  logic          in_hs_s;
  mac_addr_t     da_s;

  assign in_hs_s = in_tvalid & in_tready;
  assign da_s    = {hdr_buf_r[0], hdr_buf_r[1], hdr_buf_r[2], hdr_buf_r[3], hdr_buf_r[4], in_tdata};
  assign idx_s   = cnt_r + 3'd1;

  // Port drive: payload is a combinational pass-through, header replay comes from registers.
  always_comb begin
    in_tready  = 1'b0;
    out_tvalid = ov_r;
    out_tdata  = od_r;
    out_tlast  = ol_r;
    case (state_r)
      HDR:   in_tready = run_r;
      FLUSH: in_tready = 1'b0;
      PASS: begin
        in_tready  = out_tready;
        out_tvalid = in_tvalid;
        out_tdata  = in_tdata;
        out_tlast  = in_tlast;
      end
      DROP:    in_tready = run_r;
      default: in_tready = 1'b0;
    endcase
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    last_nxt  = last_r;
    ov_nxt    = ov_r;
    od_nxt    = od_r;
    ol_nxt    = ol_r;
    case (state_r)
      HDR: begin
        if (in_hs_s) begin
          if (cnt_r == HDR_LAST_IDX) begin
            cnt_nxt = 3'd0;
            if (mac_match(da_s, MAC_ADDR, ACCEPT_BCAST)) begin
              state_nxt = FLUSH;
              last_nxt  = in_tlast;
              ov_nxt    = 1'b1;
              od_nxt    = hdr_buf_r[0];
              ol_nxt    = 1'b0;
            end else if (in_tlast) begin
              state_nxt = HDR;
            end else begin
              state_nxt = DROP;
            end
          end else if (in_tlast) begin
            cnt_nxt = 3'd0;
          end else begin
            cnt_nxt = idx_s;
          end
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      FLUSH: begin
        // cnt_r doubles as the replay index while the header drains.
        if (out_tready) begin
          if (cnt_r == HDR_LAST_IDX) begin
            cnt_nxt   = 3'd0;
            ov_nxt    = 1'b0;
            od_nxt    = 8'd0;
            ol_nxt    = 1'b0;
            state_nxt = last_r ? HDR : PASS;
          end else begin
            cnt_nxt = idx_s;
            od_nxt  = hdr_buf_r[idx_s];
            ol_nxt  = (idx_s == HDR_LAST_IDX) && last_r;
          end
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      PASS: begin
        if (in_hs_s && in_tlast) begin
          state_nxt = HDR;
          cnt_nxt   = 3'd0;
        end else begin
          state_nxt = PASS;
        end
      end
      DROP: begin
        if (in_hs_s && in_tlast) begin
          state_nxt = HDR;
        end else begin
          state_nxt = DROP;
        end
      end
      default: begin
        state_nxt = HDR;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, counter and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HDR;
      cnt_r   <= 3'd0;
      last_r  <= 1'b0;
      run_r   <= 1'b0;
      ov_r    <= 1'b0;
      od_r    <= 8'd0;
      ol_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      last_r  <= last_nxt;
      run_r   <= 1'b1;
      ov_r    <= ov_nxt;
      od_r    <= od_nxt;
      ol_r    <= ol_nxt;
    end
  end

  // Header capture buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ETH_HDR_DA_BYTES; i++) hdr_buf_r[i] <= 8'd0;
    end else if ((state_r == HDR) && in_hs_s) begin
      hdr_buf_r[cnt_r] <= in_tdata;
    end else begin
      for (int i = 0; i < ETH_HDR_DA_BYTES; i++) hdr_buf_r[i] <= hdr_buf_r[i];
    end
  end

endmodule

// File: tb/tb_mac_filter.sv
// Directed bench for mac_filter: one default instance plus one with broadcast acceptance.
module tb_mac_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_tvalid, in_tlast, sel, out_tready;
  logic [7:0] in_tdata;
  logic       v_a, v_b;
  logic       rdy_a, rdy_b;
  logic       ov_a, ov_b, ol_a, ol_b;
  logic [7:0] od_a, od_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_d[$];
  logic       cap_l[$];
  logic [7:0] cap_bd[$];
  logic       cap_bl[$];
  int         unstable = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  logic [7:0] good_q[$];
  logic [7:0] bad_q[$];
  logic [7:0] runt_q[$];
  logic [7:0] bc_q[$];
  logic [7:0] part_q[$];

  assign v_a = in_tvalid & ~sel;
  assign v_b = in_tvalid & sel;

  always #5 clk = ~clk;

  mac_filter dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(v_a), .in_tready(rdy_a), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .out_tvalid(ov_a), .out_tready(out_tready), .out_tdata(od_a), .out_tlast(ol_a)
  );

  mac_filter #(.ACCEPT_BCAST(1'b1)) dut_bc (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(v_b), .in_tready(rdy_b), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .out_tvalid(ov_b), .out_tready(out_tready), .out_tdata(od_b), .out_tlast(ol_b)
  );

  // Output capture and hold-stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov_a && out_tready) begin
        cap_d.push_back(od_a);
        cap_l.push_back(ol_a);
      end
      if (ov_b && out_tready) begin
        cap_bd.push_back(od_b);
        cap_bl.push_back(ol_b);
      end
      if (prev_stall && (!ov_a || od_a !== prev_data)) unstable++;
      prev_stall = ov_a && !out_tready;
      prev_data  = od_a;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b[$], input bit to_bc, input bit bp,
                      input bit last_en, output int stalls);
    bit hs;
    int guard;
    stalls = 0;
    sel = to_bc;
    for (int i = 0; i < b.size(); i++) begin
      in_tvalid = 1'b1;
      in_tdata  = b[i];
      in_tlast  = last_en && (i == b.size() - 1);
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        @(negedge clk);
        hs = to_bc ? rdy_b : rdy_a;
        if (!hs) stalls++;
        @(posedge clk);
        #1;
        if (bp) out_tready = ~out_tready;
        guard++;
        if (!hs && guard > 100) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout byte %0d got no ready want ready within 100 cycles", i);
          hs = 1'b1;
        end
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    out_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL rst_in_tready got %b want 0", rdy_a); end
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL rst_out_tvalid got %b want 0", ov_a); end
    n_cmp++; if (od_a !== 8'h00) begin n_bad++; $display("FAIL rst_out_tdata got %h want 00", od_a); end
    n_cmp++; if (ol_a !== 1'b0) begin n_bad++; $display("FAIL rst_out_tlast got %b want 0", ol_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_good();
    int st;
    cap_d.delete(); cap_l.delete();
    send(good_q, 1'b0, 1'b0, 1'b1, st);
    n_cmp++; if (st !== 6) begin n_bad++; $display("FAIL good_stall got %0d want 6", st); end
    n_cmp++; if (cap_d.size() !== 19) begin n_bad++; $display("FAIL good_len got %0d want 19", cap_d.size()); end
    for (int i = 0; i < cap_d.size() && i < 19; i++) begin
      n_cmp++;
      if (cap_d[i] !== good_q[i] || cap_l[i] !== logic'(i == 18)) begin
        n_bad++;
        $display("FAIL good_byte[%0d] got %h/%b want %h/%b", i, cap_d[i], cap_l[i], good_q[i], i == 18);
      end
    end
  endtask

  task automatic test_bad();
    int st;
    cap_d.delete(); cap_l.delete();
    send(bad_q, 1'b0, 1'b0, 1'b1, st);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL bad_stall got %0d want 0", st); end
    n_cmp++; if (cap_d.size() !== 0) begin n_bad++; $display("FAIL bad_out got %0d bytes want 0", cap_d.size()); end
    test_good();
  endtask

  task automatic test_runt();
    int st;
    cap_d.delete(); cap_l.delete();
    send(runt_q, 1'b0, 1'b0, 1'b1, st);
    n_cmp++; if (cap_d.size() !== 0) begin n_bad++; $display("FAIL runt_out got %0d bytes want 0", cap_d.size()); end
    test_good();
  endtask

  task automatic test_backpressure();
    int st;
    cap_d.delete(); cap_l.delete();
    unstable = 0;
    send(good_q, 1'b0, 1'b1, 1'b1, st);
    n_cmp++; if (cap_d.size() !== 19) begin n_bad++; $display("FAIL bp_len got %0d want 19", cap_d.size()); end
    for (int i = 0; i < cap_d.size() && i < 19; i++) begin
      n_cmp++;
      if (cap_d[i] !== good_q[i] || cap_l[i] !== logic'(i == 18)) begin
        n_bad++;
        $display("FAIL bp_byte[%0d] got %h/%b want %h/%b", i, cap_d[i], cap_l[i], good_q[i], i == 18);
      end
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
  endtask

  task automatic test_bcast();
    int st;
    cap_d.delete(); cap_l.delete(); cap_bd.delete(); cap_bl.delete();
    send(bc_q, 1'b0, 1'b0, 1'b1, st);
    n_cmp++; if (cap_d.size() !== 0) begin n_bad++; $display("FAIL bcast_off got %0d bytes want 0", cap_d.size()); end
    send(bc_q, 1'b1, 1'b0, 1'b1, st);
    sel = 1'b0;
    n_cmp++; if (cap_bd.size() !== 10) begin n_bad++; $display("FAIL bcast_on_len got %0d want 10", cap_bd.size()); end
    for (int i = 0; i < cap_bd.size() && i < 10; i++) begin
      n_cmp++;
      if (cap_bd[i] !== bc_q[i] || cap_bl[i] !== logic'(i == 9)) begin
        n_bad++;
        $display("FAIL bcast_byte[%0d] got %h/%b want %h/%b", i, cap_bd[i], cap_bl[i], bc_q[i], i == 9);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    int st;
    send(part_q, 1'b0, 1'b0, 1'b0, st);
    in_tvalid = 1'b1;
    in_tdata  = 8'h12;
    in_tlast  = 1'b0;
    @(negedge clk);
    n_cmp++; if (ov_a !== 1'b1) begin n_bad++; $display("FAIL midpass_valid got %b want 1", ov_a); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL midrst_out_tvalid got %b want 0", ov_a); end
    n_cmp++; if (od_a !== 8'h00) begin n_bad++; $display("FAIL midrst_out_tdata got %h want 00", od_a); end
    n_cmp++; if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL midrst_in_tready got %b want 0", rdy_a); end
    in_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_good();
  endtask

  initial begin
    good_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h35, 8'h12,
               8'h34, 8'h56, 8'h08, 8'h00, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    bad_q  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h00,
               8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
    runt_q = '{8'hDE, 8'hAD, 8'hBE};
    bc_q   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'h00, 8'h41, 8'h42};
    part_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h35};
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    in_tdata   = 8'h00;
    sel        = 1'b0;
    out_tready = 1'b1;
    test_reset();
    test_good();
    test_bad();
    test_runt();
    test_backpressure();
    test_bcast();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
